// File: rtl/flow_led_ctrl.sv
// ---------------------------------------------------------------------------
// flow_led_ctrl
//   Parametrised LED sequencer. The design has LED_NUM LEDs, a step period of
//   STEP_CNT clocks and a selectable output polarity. It supports four runtime
//   patterns: rotate-left, rotate-right, ping-pong and bar fill. It also has a
//   pause input and a synchronous restart.
//
// Parameters
//   LED_NUM        number of LEDs (>= 2)
//   STEP_CNT       clocks per pattern step (>= 2)
//   LED_ACTIVE_LOW 1: led = ~pattern, 0: led = pattern
//
// Ports
//   sys_clk    in   1        system clock
//   sys_rst_n  in   1        asynchronous reset, active low
//   mode       in   2        00 rot-left, 01 rot-right, 10 ping-pong, 11 fill
//   pause      in   1        1: freeze step counter and pattern
//   restart    in   1        sync pulse: restart the sequence in the current mode
//   led        out  LED_NUM  LED drive, polarity per LED_ACTIVE_LOW
//   step_tick  out  1        1-cycle pulse coincident with each new pattern
// ---------------------------------------------------------------------------
module flow_led_ctrl #(
    parameter int LED_NUM        = 4,
    parameter int STEP_CNT       = 25_000_000,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode,
    input  logic               pause,
    input  logic               restart,
    output logic [LED_NUM-1:0] led,
    output logic               step_tick
);

    localparam int CNT_W = $clog2(STEP_CNT);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CNT - 1);
    localparam logic [LED_NUM-1:0] POL_MASK = {LED_NUM{LED_ACTIVE_LOW}};
    localparam logic [LED_NUM-1:0] PAT_LSB  = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] PAT_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_ROL  = 2'b00,
        MODE_ROR  = 2'b01,
        MODE_PING = 2'b10,
        MODE_FILL = 2'b11
    } mode_t;

    // Ping-pong travel direction; only advanced while mode_q is MODE_PING.
    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [LED_NUM-1:0] pattern_q, pattern_d;
    dir_t               dir_q,     dir_d;
    mode_t              mode_q,    mode_d;
    logic [LED_NUM-1:0] led_d;
    logic               step_tick_d;
    logic               step_edge;
    mode_t              mode_in;

    assign mode_in   = mode_t'(mode);
    assign step_edge = (cnt_q == CNT_LAST);

    // Starting pattern of each mode. Rotate-right starts at the top LED so
    // that its first visible move is downward.
    function automatic logic [LED_NUM-1:0] init_pattern(input mode_t m);
        logic [LED_NUM-1:0] p;
        p = PAT_LSB;
        if (m == MODE_ROR) begin
            p = PAT_MSB;
        end
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // State register. led and step_tick are registered from the same next
    // values as pattern, so they change on the same edge as the pattern.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= '0;
            pattern_q <= PAT_LSB;
            dir_q     <= DIR_L;
            mode_q    <= MODE_ROL;
            led       <= PAT_LSB ^ POL_MASK;
            step_tick <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            led       <= led_d;
            step_tick <= step_tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Priority: restart > pause > step.
    // The mode input is only sampled on restart or at a step edge, so a mode
    // change between step edges stays invisible until the next step edge.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;

        if (restart) begin
            cnt_d     = '0;
            mode_d    = mode_in;
            pattern_d = init_pattern(mode_in);
            dir_d     = DIR_L;
        end else if (pause) begin
            // Hold everything. A step due on this clock is deferred to the
            // first unpaused clock because cnt stays at CNT_LAST.
        end else if (step_edge) begin
            cnt_d = '0;
            if (mode_in != mode_q) begin
                mode_d    = mode_in;
                pattern_d = init_pattern(mode_in);
                dir_d     = DIR_L;
            end else begin
                case (mode_q)
                    MODE_ROL: begin
                        pattern_d = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
                    end
                    MODE_ROR: begin
                        pattern_d = {pattern_q[0], pattern_q[LED_NUM-1:1]};
                    end
                    MODE_PING: begin
                        // Reverse on reaching an end LED. This keeps each end
                        // LED lit for exactly one step (period 2N-2).
                        case (dir_q)
                            DIR_L: begin
                                if (pattern_q[LED_NUM-1]) begin
                                    dir_d     = DIR_R;
                                    pattern_d = pattern_q >> 1;
                                end else begin
                                    pattern_d = pattern_q << 1;
                                end
                            end
                            DIR_R: begin
                                if (pattern_q[0]) begin
                                    dir_d     = DIR_L;
                                    pattern_d = pattern_q << 1;
                                end else begin
                                    pattern_d = pattern_q >> 1;
                                end
                            end
                            default: begin
                                dir_d = DIR_L;
                            end
                        endcase
                    end
                    MODE_FILL: begin
                        // After all LEDs are lit, go to all-dark. The next
                        // step starts a new fill (period N+1).
                        if (pattern_q == '1) begin
                            pattern_d = '0;
                        end else begin
                            pattern_d = {pattern_q[LED_NUM-2:0], 1'b1};
                        end
                    end
                    default: begin
                        pattern_d = PAT_LSB;
                    end
                endcase
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: polarity applied to the next pattern. The tick fires only
    // when a step actually takes place.
    // -----------------------------------------------------------------------
    always_comb begin
        led_d       = pattern_d ^ POL_MASK;
        step_tick_d = 1'b0;
        if (!restart && !pause && step_edge) begin
            step_tick_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_flow_led_ctrl.sv
module tb_flow_led_ctrl;

    localparam int STEP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       pause = 1'b0;
    logic       restart = 1'b0;

    logic [3:0] led4;
    logic       tick4;
    logic [7:0] led8;
    logic       tick8;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    flow_led_ctrl #(.LED_NUM(4), .STEP_CNT(STEP), .LED_ACTIVE_LOW(1'b0)) u_dut4 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .mode      (mode),
        .pause     (pause),
        .restart   (restart),
        .led       (led4),
        .step_tick (tick4)
    );

    flow_led_ctrl #(.LED_NUM(8), .STEP_CNT(STEP), .LED_ACTIVE_LOW(1'b1)) u_dut8 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .mode      (mode),
        .pause     (pause),
        .restart   (restart),
        .led       (led8),
        .step_tick (tick8)
    );

    // ---------------- behavioural model ----------------
    // The model tracks the step counter, the latched mode and a phase index k
    // within the current mode's cycle. The pattern is computed from (mode, k)
    // arithmetically.
    int m_cnt  = 0;
    int m_mq   = 0;
    int m_k[2] = '{0, 0};
    bit m_tick = 1'b0;
    int nled[2] = '{4, 8};

    function automatic int period(input int mq, input int n);
        case (mq)
            2:       return 2 * n - 2;
            3:       return n + 1;
            default: return n;
        endcase
    endfunction

    function automatic logic [7:0] model_pat(input int mq, input int k, input int n);
        int pos;
        int lvl;
        logic [7:0] one;
        one = 8'd1;
        case (mq)
            0: return one << (k % n);
            1: return one << (n - 1 - (k % n));
            2: begin
                pos = (k < n) ? k : (2 * n - 2 - k);
                return one << pos;
            end
            default: begin
                lvl = (1 + k) % (n + 1);
                return (one << lvl) - 8'd1;
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_mq   <= 0;
            m_k[0] <= 0;
            m_k[1] <= 0;
            m_tick <= 1'b0;
        end else if (restart) begin
            m_cnt  <= 0;
            m_mq   <= int'(mode);
            m_k[0] <= 0;
            m_k[1] <= 0;
            m_tick <= 1'b0;
        end else if (pause) begin
            m_tick <= 1'b0;
        end else if (m_cnt == STEP - 1) begin
            m_cnt  <= 0;
            m_tick <= 1'b1;
            if (int'(mode) != m_mq) begin
                m_mq   <= int'(mode);
                m_k[0] <= 0;
                m_k[1] <= 0;
            end else begin
                m_k[0] <= (m_k[0] + 1) % period(m_mq, nled[0]);
                m_k[1] <= (m_k[1] + 1) % period(m_mq, nled[1]);
            end
        end else begin
            m_cnt  <= m_cnt + 1;
            m_tick <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [7:0] e4;
        logic [7:0] e8;
        if (chk_en) begin
            e4 = model_pat(m_mq, m_k[0], 4);
            e8 = model_pat(m_mq, m_k[1], 8) ^ 8'hFF;
            checks++;
            if (led4 !== e4[3:0] || tick4 !== m_tick) begin
                failures++;
                $display("FAIL model_n4 t=%0t: led=%b tick=%b expected led=%b tick=%b",
                         $time, led4, tick4, e4[3:0], m_tick);
            end
            checks++;
            if (led8 !== e8 || tick8 !== m_tick) begin
                failures++;
                $display("FAIL model_n8 t=%0t: led=%h tick=%b expected led=%h tick=%b",
                         $time, led8, tick8, e8, m_tick);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check4(input string name, input logic [3:0] e, input logic et);
        checks++;
        if (led4 !== e || tick4 !== et) begin
            failures++;
            $display("FAIL %s: led=%b tick=%b expected led=%b tick=%b",
                     name, led4, tick4, e, et);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] e);
        checks++;
        if (led8 !== e) begin
            failures++;
            $display("FAIL %s: led8=%h expected %h", name, led8, e);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [3:0] pp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] ror_seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Test 1: reset, rotate left
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        clk_n(2);
        check4("reset_n4", 4'b0001, 1'b0);
        check8("reset_n8", 8'hFE);
        rst_n = 1'b1;
        clk_n(5);
        check4("rol_step1", 4'b0010, 1'b1);
        check8("rol_n8_1", 8'hFD);
        clk_n(1);
        check4("rol_tick_low", 4'b0010, 1'b0);
        clk_n(4);
        check4("rol_step2", 4'b0100, 1'b1);
        check8("rol_n8_2", 8'hFB);
        clk_n(5);
        check4("rol_step3", 4'b1000, 1'b1);
        clk_n(5);
        check4("rol_wrap", 4'b0001, 1'b1);

        // Test 2: mode change mid-step is deferred to the step edge
        clk_n(10);
        check4("rol_0100", 4'b0100, 1'b1);
        clk_n(2);
        mode = 2'b01;
        clk_n(1);
        check4("mode_defer", 4'b0100, 1'b0);
        clk_n(2);
        check4("ror_init", 4'b1000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            clk_n(5);
            check4("ror_seq", ror_seq[i], 1'b1);
        end

        // Test 3: ping-pong from restart
        mode = 2'b10;
        restart = 1'b1;
        clk_n(1);
        restart = 1'b0;
        check4("pp_restart", pp_seq[0], 1'b0);
        for (int i = 1; i < 8; i++) begin
            clk_n(5);
            check4("pp_seq", pp_seq[i], 1'b1);
        end

        // Test 4: fill, pause
        mode = 2'b11;
        restart = 1'b1;
        clk_n(1);
        restart = 1'b0;
        check4("fill_restart", 4'b0001, 1'b0);
        clk_n(5);
        check4("fill_0011", 4'b0011, 1'b1);
        clk_n(2);
        pause = 1'b1;
        clk_n(12);
        check4("pause_hold", 4'b0011, 1'b0);
        pause = 1'b0;
        clk_n(2);
        check4("pause_resume_wait", 4'b0011, 1'b0);
        clk_n(1);
        check4("fill_0111", 4'b0111, 1'b1);
        clk_n(5);
        check4("fill_1111", 4'b1111, 1'b1);
        clk_n(5);
        check4("fill_0000", 4'b0000, 1'b1);
        clk_n(5);
        check4("fill_wrap", 4'b0001, 1'b1);
        clk_n(4);
        pause = 1'b1;
        clk_n(3);
        check4("pause_at_last", 4'b0001, 1'b0);
        pause = 1'b0;
        clk_n(1);
        check4("deferred_step", 4'b0011, 1'b1);

        // Test 5: restart beats pause; async reset
        clk_n(3);
        restart = 1'b1;
        pause = 1'b1;
        clk_n(1);
        restart = 1'b0;
        pause = 1'b0;
        check4("restart_pause", 4'b0001, 1'b0);
        clk_n(4);
        check4("restart_cnt0", 4'b0001, 1'b0);
        clk_n(1);
        check4("restart_step", 4'b0011, 1'b1);
        clk_n(2);
        #2 rst_n = 1'b0;
        #1;
        check4("async_reset", 4'b0001, 1'b0);
        check8("async_reset_n8", 8'hFE);
        clk_n(3);
        check4("reset_hold", 4'b0001, 1'b0);
        mode = 2'b00;
        rst_n = 1'b1;
        clk_n(5);
        check4("post_reset_rol", 4'b0010, 1'b1);
        check8("post_reset_n8", 8'hFD);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
